// File: rtl/nios_system_pio_pkg.sv
// rtl/nios_system_pio_pkg.sv - shared address map and edge-type encodings for PIO slaves
package nios_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_pio_in_edge_irq_if.sv
// rtl/nios_system_pio_in_edge_irq_if.sv - Avalon-MM slave bus bundle for the PIO input block
interface nios_system_pio_in_edge_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_system_pio_sync.sv
// rtl/nios_system_pio_sync.sv - WIDTH x STAGES flop synchroniser with synchronous reset
module nios_system_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stg <= '0;
        end else begin
            stg <= {stg[STAGES-2:0], d};
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/nios_system_pio_in_edge_irq.sv
// rtl/nios_system_pio_in_edge_irq.sv - input PIO with per-bit edge capture, irq mask and level irq
module nios_system_pio_in_edge_irq
    import nios_system_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int BIT_CLEAR   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    nios_system_pio_in_edge_irq_if.slave  bus,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_n;
    logic [2:0]       arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_n;
    logic [31:0]      rd_q;
    logic             unused_wdata;

    nios_system_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (s)
    );

    assign armed        = (arm_cnt == 3'(ARM_CYCLES));
    assign wr_en        = bus.chipselect && !bus.write_n;
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_det = s & ~p;
            EDGE_FALL: edge_det = ~s & p;
            default:   edge_det = s ^ p;
        endcase
    end

    // Clear is applied first so a same-cycle capture always survives it.
    always_comb begin
        edgecap_n = edgecap;
        if (wr_en && bus.address == ADDR_EDGECAP) begin
            if (BIT_CLEAR != 0) begin
                edgecap_n = edgecap & ~bus.writedata[WIDTH-1:0];
            end else begin
                edgecap_n = '0;
            end
        end
        if (armed) begin
            edgecap_n = edgecap_n | edge_det;
        end
    end

    always_comb begin
        rd_n = '0;
        case (bus.address)
            ADDR_DATA:    rd_n = 32'(s);
            ADDR_IRQMASK: rd_n = 32'(irqmask);
            ADDR_EDGECAP: rd_n = 32'(edgecap);
            default:      rd_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p       <= '0;
            irqmask <= '0;
            edgecap <= '0;
            rd_q    <= '0;
            arm_cnt <= '0;
        end else begin
            p <= s;
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
            if (wr_en && bus.address == ADDR_IRQMASK) begin
                irqmask <= bus.writedata[WIDTH-1:0];
            end
            edgecap <= edgecap_n;
            rd_q    <= rd_n;
        end
    end

    assign irq          = |(edgecap & irqmask);
    assign bus.readdata = rd_q;

endmodule

// File: tb/tb_nios_system_pio_in_edge_irq.sv
// tb/tb_nios_system_pio_in_edge_irq.sv - directed scoreboard bench for the edge-irq input PIO
module tb_nios_system_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic [2:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [31:0] in_c;
    logic        irq_a;
    logic        irq_b;
    logic        irq_c;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    nios_system_pio_in_edge_irq_if bus_a ();
    nios_system_pio_in_edge_irq_if bus_b ();
    nios_system_pio_in_edge_irq_if bus_c ();

    assign bus_a.address = address;  assign bus_a.chipselect = cs[0];
    assign bus_a.write_n = write_n;  assign bus_a.writedata  = writedata;
    assign bus_b.address = address;  assign bus_b.chipselect = cs[1];
    assign bus_b.write_n = write_n;  assign bus_b.writedata  = writedata;
    assign bus_c.address = address;  assign bus_c.chipselect = cs[2];
    assign bus_c.write_n = write_n;  assign bus_c.writedata  = writedata;

    nios_system_pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .BIT_CLEAR(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .in_port(in_a), .irq(irq_a));
    nios_system_pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .BIT_CLEAR(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .in_port(in_b), .irq(irq_b));
    nios_system_pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(0), .BIT_CLEAR(1)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c), .in_port(in_c), .irq(irq_c));

    function automatic logic [31:0] rdata(input int d);
        case (d)
            0:       return bus_a.readdata;
            1:       return bus_b.readdata;
            default: return bus_c.readdata;
        endcase
    endfunction

    function automatic logic [31:0] irqs(input int d);
        case (d)
            0:       return {31'b0, irq_a};
            1:       return {31'b0, irq_b};
            default: return {31'b0, irq_c};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        address   = a;
        writedata = v;
        write_n   = 1'b0;
        cs        = 3'(1 << d);
        @(negedge clk);
        write_n   = 1'b1;
        cs        = 3'b000;
    endtask

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] v, input string tag);
        @(negedge clk);
        address = a;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check(tag, rdata(d));
    endtask

    task automatic chk_irq(input int d, input logic v, input string tag);
        exp_q.push_back({31'b0, v});
        check(tag, irqs(d));
    endtask

    initial begin
        reset = 1'b1; cs = 3'b000; write_n = 1'b1; address = 2'd0; writedata = '0;
        in_a = 8'hFF; in_b = 8'h00; in_c = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            exp_q.push_back(32'h0);
            check("reset_readdata", rdata(d));
            chk_irq(d, 1'b0, "reset_irq");
        end

        // Release with in_a high: data appears after SYNC_STAGES+1 edges, no spurious capture.
        @(negedge clk);
        reset = 1'b0; address = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back((k >= 3) ? 32'hFF : 32'h0);
            exp_q.push_back(32'h0);
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("arm_data_a", rdata(0));
            check("arm_irq_a", irqs(0));
        end
        rd(0, 2'd3, 32'h0, "arm_edgecap_a");

        // Rising edge on bit 0 with bit 0 masked in.
        wr(0, 2'd2, 32'h1);
        @(negedge clk); in_a = 8'h00;
        repeat (4) @(negedge clk);
        rd(0, 2'd3, 32'h0, "fall_ignored_a");
        @(negedge clk); in_a = 8'h01;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("rise_irq_latency_a", irqs(0));
        end
        rd(0, 2'd3, 32'h01, "rise_edgecap_a");
        wr(0, 2'd3, 32'h01);
        chk_irq(0, 1'b0, "w1c_irq_a");
        rd(0, 2'd3, 32'h00, "w1c_edgecap_a");

        // Masking and selective clear.
        wr(0, 2'd2, 32'h0);
        @(negedge clk); in_a = 8'h00;
        repeat (4) @(negedge clk);
        in_a = 8'h09;
        repeat (4) @(negedge clk);
        rd(0, 2'd3, 32'h09, "masked_edgecap_a");
        chk_irq(0, 1'b0, "masked_irq_a");
        wr(0, 2'd2, 32'h08);
        chk_irq(0, 1'b1, "unmask_irq_a");
        wr(0, 2'd3, 32'h08);
        rd(0, 2'd3, 32'h01, "sel_clear_edgecap_a");
        chk_irq(0, 1'b0, "sel_clear_irq_a");

        // Bit 2 is captured on the same edge that a W1C of bit 2 lands.
        @(negedge clk); in_a = 8'h0D;
        @(negedge clk);
        wr(0, 2'd3, 32'h04);
        rd(0, 2'd3, 32'h05, "set_wins_a");

        wr(0, 2'd0, 32'hFF);
        wr(0, 2'd1, 32'hFF);
        rd(0, 2'd1, 32'h0, "reserved_a");
        rd(0, 2'd2, 32'h08, "mask_kept_a");
        rd(0, 2'd0, 32'h0D, "data_a");

        // Any-edge, clear-all variant.
        @(negedge clk); in_b = 8'h22;
        repeat (4) @(negedge clk);
        rd(1, 2'd3, 32'h22, "any_rise_b");
        wr(1, 2'd3, 32'h0);
        rd(1, 2'd3, 32'h00, "clear_all_b");
        @(negedge clk); in_b = 8'h00;
        repeat (4) @(negedge clk);
        rd(1, 2'd3, 32'h22, "any_fall_b");
        chk_irq(1, 1'b0, "masked_irq_b");
        wr(1, 2'd2, 32'hFF);
        chk_irq(1, 1'b1, "irq_b");

        // 32-bit, three-stage variant: four-cycle latency.
        @(negedge clk); address = 2'd0; in_c = 32'hA5C3_0F81;
        for (int k = 1; k <= 4; k++) exp_q.push_back((k == 4) ? 32'hA5C3_0F81 : 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("latency_c", rdata(2));
        end
        rd(2, 2'd3, 32'hA5C3_0F81, "edgecap_c");
        rd(2, 2'd2, 32'h0, "mask_c");
        chk_irq(2, 1'b0, "irq_c");

        // Mid-operation reset with everything captured and unmasked.
        @(negedge clk); in_a = 8'h00;
        repeat (4) @(negedge clk);
        in_a = 8'hFF;
        repeat (4) @(negedge clk);
        wr(0, 2'd2, 32'hFF);
        rd(0, 2'd3, 32'hFF, "pre_reset_edgecap_a");
        chk_irq(0, 1'b1, "pre_reset_irq_a");
        @(negedge clk); reset = 1'b1; address = 2'd3;
        @(posedge clk); #1;
        chk_irq(0, 1'b0, "mid_reset_irq_a");
        exp_q.push_back(32'h0);
        check("mid_reset_readdata_a", rdata(0));
        @(negedge clk); reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check("rearm_edgecap_a", rdata(0));
            check("rearm_irq_a", irqs(0));
        end
        rd(0, 2'd2, 32'h0, "post_reset_mask_a");
        rd(0, 2'd0, 32'hFF, "post_reset_data_a");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_system_pio_in_edge_irq.md
# nios_system_pio_in_edge_irq

Parametrised Avalon-MM input PIO slave for the Nios II system. It samples a WIDTH-bit external input bus through a synchroniser and exposes it at address 0. It adds per-bit edge capture, an interrupt mask and a level interrupt to the processor. It sits on the system interconnect alongside the other PIO slaves and replaces the single-bit, data-only input port.

## Interface
Parameters:
- WIDTH, 8: input bus width, legal range 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, legal range 2..4.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- BIT_CLEAR, 1: 1 = edgecapture is write-1-to-clear per bit; 0 = any write clears all bits.

Ports:
- clk  in  1  system clock; the single clock for the block.
- reset  in  1  synchronous, active-high reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is `chipselect && !write_n` at a rising edge of clk.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data; bits 31:WIDTH are always 0.
- irq  out  1  level interrupt, `|(edgecapture & irqmask)`, decoded combinationally from registers.

## Operation
Address map:
- 0 = data (RO): synchronised in_port.
- 1 = reserved: reads 0, writes ignored.
- 2 = irqmask (RW).
- 3 = edgecapture (R/W-clear).

Behaviour:
- Synchroniser: each bit of in_port passes through SYNC_STAGES flops; the last stage is `s`. Register `p <= s` every cycle.
- Edge detect per bit:
  - rise = s & ~p
  - fall = ~s & p
  - any = s ^ p
  - EDGE_TYPE selects which one is used.
- Edgecapture set: a detected edge sets the edgecapture bit at the next clk edge, but only when armed. Bits are sticky until cleared.
- Edgecapture clear:
  - BIT_CLEAR=1: a write to address 3 clears the bits where writedata is 1.
  - BIT_CLEAR=0: any write to address 3 clears all bits.
  - If an edge and a clear hit the same bit in the same cycle, the set wins and the edge is not lost.
- Irqmask: a write to address 2 loads irqmask <= writedata[WIDTH-1:0]. Writes to addresses 0 and 1 have no effect.
- Arm counter: after reset, edge detection is suppressed for SYNC_STAGES+1 cycles while the synchroniser fills. This prevents an input that is high at reset from producing a spurious rising edge. The counter saturates once armed and is cleared only by reset.
- Read mux: readdata <= zero-extended mux(address) on every cycle, independent of chipselect. This is read latency 1.

## Timing
- Reset (synchronous, while reset=1): synchroniser flops, p, irqmask, edgecapture, readdata and the arm counter are all 0. irq=0. Reset takes priority over writes in the same cycle.
- Reset asserted mid-operation: all state is cleared at that edge and the arm sequence restarts.
- in_port to s: a change on in_port before edge 1 appears on s after edge SYNC_STAGES.
- s to readdata: with address=0 held, readdata shows the change after edge SYNC_STAGES+1.
- Edge to edgecapture and irq: edgecapture sets at edge SYNC_STAGES+1, and irq rises right after it if the bit is masked in.
- Write visibility: a write at edge k takes effect at edge k. A read presented in cycle k+1 returns the new value after edge k+1.
- Clearing edgecapture with a write at edge k drops irq right after edge k, unless another edge is captured in the same cycle.
- Pulse width: input pulses shorter than one clk period may be missed. Only pulses of at least one clock are guaranteed to be detected.

## Structure
- Shared package nios_system_pio_pkg:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - the EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module nios_system_pio_sync: a WIDTH x SYNC_STAGES synchroniser with synchronous reset. It is reused by the other PIO inputs.
- Top level: arm counter, edge detect, edgecapture and irqmask registers, read mux.

## Test plan
- Reset release with in_port=8'hFF (EDGE_TYPE=0): data reads 8'hFF after SYNC_STAGES+1 cycles; edgecapture reads 0; irq=0 throughout.
- Rising edge and interrupt:
  - Setup: armed, irqmask=8'h01.
  - Stimulus: toggle in_port[0] 0->1.
  - Required: edgecapture=8'h01 and irq=1 after SYNC_STAGES+1 cycles.
  - Then write 8'h01 to address 3: irq=0 next cycle and edgecapture=0.
- Masking and selective clear:
  - Setup: irqmask=0.
  - Stimulus: edges on bits 0 and 3.
  - Required: edgecapture=8'h09 and irq=0; writing irqmask=8'h08 raises irq; W1C 8'h08 leaves 8'h01 and irq=0.
- Set-wins: a W1C of bit 2 in the same cycle that bit 2 is captured leaves edgecapture[2]=1.
- Parameter variants:
  - EDGE_TYPE=2, BIT_CLEAR=0: both transitions of a pulse are captured; writing 0 to address 3 clears all bits.
  - WIDTH=32, SYNC_STAGES=3: latency is 4 cycles; readdata[31:0] matches in_port.
- Mid-operation reset: reset asserted with edgecapture=8'hFF and irqmask=8'hFF clears everything at that edge. Readdata is 0 the next cycle, and no capture occurs during the re-arm window.
